// File: rtl/lamp_dimmer.sv
// lamp_dimmer: ramps a lamp brightness toward a per-state target and blinks it in ALERT.
// Latency: first ramp step within RAMP_DIV clocks of a state change; Lamp_PWM lags Brightness by 1 clock.
// Backpressure: none; the lamp is a pure sink and Present_State is sampled every clock.
//
// Ports:
//   Clock          - sole clock, all state updates on the rising edge
//   Reset_n        - asynchronous active-low reset
//   Present_State  - 00 OFF, 01 DIM, 10 ON, 11 ALERT (blink)
//   Brightness     - registered lamp level 0..255
//   Lamp_PWM       - registered PWM drive, N high clocks per 256 for Brightness N
//   Ramp_Busy      - Brightness still moving toward target (never in ALERT)
//   At_Target      - Brightness equals target (never in ALERT)

module lamp_dimmer #(
  parameter int unsigned RAMP_DIV     = 16,
  parameter logic [7:0]  DIM_LEVEL    = 8'd64,
  parameter logic [7:0]  ON_LEVEL     = 8'd255,
  parameter int unsigned BLINK_CYCLES = 1024
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [1:0] Present_State,
  output logic [7:0] Brightness,
  output logic       Lamp_PWM,
  output logic       Ramp_Busy,
  output logic       At_Target
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_DIM   = 2'b01,
    ST_ON    = 2'b10,
    ST_ALERT = 2'b11
  } state_t;

  localparam logic [15:0] PRE_LAST   = 16'(RAMP_DIV - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_CYCLES - 1);

  // Registered state
  logic [15:0] r_prescale;
  logic [15:0] r_blink_cnt;
  logic        r_blink_hi;     // 1 while the blink is in its ON_LEVEL phase
  logic        r_in_alert;     // Present_State was ALERT on the previous edge
  logic [7:0]  r_brightness;
  logic [7:0]  r_pwm_cnt;
  logic        r_lamp_pwm;

  // Combinational helpers
  state_t      w_state;
  logic [7:0]  w_target;
  logic        w_alert;
  logic        w_alert_entry;
  logic        w_tick;
  logic        w_blink_tc;
  logic        w_pwm_next;

  assign w_state       = state_t'(Present_State);
  assign w_alert       = (w_state == ST_ALERT);
  // First cycle of ALERT: the blink restarts in the high phase regardless of
  // where the previous ALERT episode left off.
  assign w_alert_entry = w_alert && !r_in_alert;
  assign w_tick        = (r_prescale == PRE_LAST);
  assign w_blink_tc    = (r_blink_cnt == BLINK_LAST);

  // Target follows the state every cycle so a mid-ramp state change redirects
  // the very next tick. ALERT has no ramp target; 0 is a don't-care there.
  always_comb begin
    w_target = 8'd0;
    case (w_state)
      ST_OFF:   w_target = 8'd0;
      ST_DIM:   w_target = DIM_LEVEL;
      ST_ON:    w_target = ON_LEVEL;
      ST_ALERT: w_target = 8'd0;
      default:  w_target = 8'd0;
    endcase
  end

  // Ramp prescaler: free-running, deliberately not restarted on state changes,
  // so the first step after a change arrives within RAMP_DIV clocks.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_prescale <= 16'd0;
    end else if (w_tick) begin
      r_prescale <= 16'd0;
    end else begin
      r_prescale <= r_prescale + 16'd1;
    end
  end

  // Blink half-period counter and phase; parked at 0 outside ALERT.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_blink_cnt <= 16'd0;
      r_blink_hi  <= 1'b0;
      r_in_alert  <= 1'b0;
    end else begin
      r_in_alert <= w_alert;
      if (!w_alert) begin
        r_blink_cnt <= 16'd0;
        r_blink_hi  <= 1'b0;
      end else if (w_alert_entry) begin
        r_blink_cnt <= 16'd0;
        r_blink_hi  <= 1'b1;
      end else if (w_blink_tc) begin
        r_blink_cnt <= 16'd0;
        r_blink_hi  <= !r_blink_hi;
      end else begin
        r_blink_cnt <= r_blink_cnt + 16'd1;
      end
    end
  end

  // Brightness: direct loads in ALERT, single-step ramp on ticks otherwise.
  // Stepping only while strictly below/above target rules out overshoot and
  // wrap at both ends of the 8-bit range.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_brightness <= 8'd0;
    end else if (w_alert_entry) begin
      r_brightness <= ON_LEVEL;
    end else if (w_alert) begin
      if (w_blink_tc) begin
        r_brightness <= r_blink_hi ? 8'd0 : ON_LEVEL;
      end
    end else if (w_tick) begin
      if (r_brightness < w_target) begin
        r_brightness <= r_brightness + 8'd1;
      end else if (r_brightness > w_target) begin
        r_brightness <= r_brightness - 8'd1;
      end
    end
  end

  // PWM: the 255 override gives a solid-on lamp, which a plain compare
  // against an 8-bit counter could never reach.
  assign w_pwm_next = (r_brightness == 8'd255) || (r_pwm_cnt < r_brightness);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pwm_cnt  <= 8'd0;
      r_lamp_pwm <= 1'b0;
    end else begin
      r_pwm_cnt  <= r_pwm_cnt + 8'd1;
      r_lamp_pwm <= w_pwm_next;
    end
  end

  assign Brightness = r_brightness;
  assign Lamp_PWM   = r_lamp_pwm;
  assign Ramp_Busy  = !w_alert && (r_brightness != w_target);
  assign At_Target  = !w_alert && (r_brightness == w_target);

endmodule

// File: tb/tb_lamp_dimmer.sv
// tb_lamp_dimmer: directed test of lamp_dimmer with RAMP_DIV=4, BLINK_CYCLES=8.
// Inputs change on the falling edge and outputs are sampled there, so each
// adv(n) step covers exactly n rising edges. "k" in comments counts rising
// edges since the most recent reset release; a ramp step lands on every k%4==0.

module tb_lamp_dimmer;

  logic       Clock;
  logic       Reset_n;
  logic [1:0] Present_State;
  logic [7:0] Brightness;
  logic       Lamp_PWM;
  logic       Ramp_Busy;
  logic       At_Target;

  int checks = 0;
  int errors = 0;
  int highs;

  lamp_dimmer #(
    .RAMP_DIV    (4),
    .DIM_LEVEL   (8'd64),
    .ON_LEVEL    (8'd255),
    .BLINK_CYCLES(8)
  ) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Present_State(Present_State),
    .Brightness   (Brightness),
    .Lamp_PWM     (Lamp_PWM),
    .Ramp_Busy    (Ramp_Busy),
    .At_Target    (At_Target)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic adv(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts Lamp_PWM high samples over 256 consecutive clocks.
  task automatic count_pwm(output int hi);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      adv(1);
      if (Lamp_PWM === 1'b1) hi++;
    end
  endtask

  initial begin
    Reset_n       = 1'b0;
    Present_State = 2'b00;
    adv(3);
    chk("rst_bright",  Brightness, 0);
    chk("rst_pwm",     Lamp_PWM,   0);
    chk("rst_attgt",   At_Target,  1);
    chk("rst_busy",    Ramp_Busy,  0);

    // Ramp up to DIM_LEVEL
    Reset_n       = 1'b1;
    Present_State = 2'b01;
    adv(3);                                   // k=3
    chk("dim_k3_bright", Brightness, 0);
    chk("dim_k3_busy",   Ramp_Busy,  1);
    chk("dim_k3_attgt",  At_Target,  0);
    adv(1);                                   // k=4
    chk("dim_k4_bright", Brightness, 1);
    adv(252);                                 // k=256
    chk("dim_k256_bright", Brightness, 64);
    chk("dim_k256_attgt",  At_Target,  1);
    chk("dim_k256_busy",   Ramp_Busy,  0);
    adv(4);                                   // k=260
    chk("dim_hold_bright", Brightness, 64);
    count_pwm(highs);                         // k=516
    chk("pwm_duty_64", highs, 64);

    // Redirect to ON, then OFF at 100
    Present_State = 2'b10;
    adv(143);                                 // k=659
    chk("on_k659_bright", Brightness, 99);
    adv(1);                                   // k=660
    chk("on_k660_bright", Brightness, 100);
    Present_State = 2'b00;
    adv(3);                                   // k=663
    chk("off_k663_bright", Brightness, 100);
    adv(1);                                   // k=664
    chk("off_k664_bright", Brightness, 99);
    adv(396);                                 // k=1060
    chk("off_k1060_bright", Brightness, 0);
    adv(40);                                  // k=1100
    chk("off_floor_bright", Brightness, 0);
    chk("off_floor_attgt",  At_Target,  1);
    chk("off_floor_busy",   Ramp_Busy,  0);
    count_pwm(highs);                         // k=1356
    chk("pwm_duty_0", highs, 0);

    // Full brightness
    Present_State = 2'b10;
    adv(1019);                                // k=2375
    chk("on_k2375_bright", Brightness, 254);
    adv(1);                                   // k=2376
    chk("on_k2376_bright", Brightness, 255);
    chk("on_top_attgt",    At_Target,  1);
    adv(4);                                   // k=2380
    count_pwm(highs);                         // k=2636
    chk("pwm_duty_255", highs, 256);

    // Down to 40, then DIM and straight into ALERT
    Present_State = 2'b00;
    adv(860);                                 // k=3496
    chk("down_k3496_bright", Brightness, 40);
    Present_State = 2'b01;
    adv(1);                                   // k=3497
    chk("pre_alert_bright", Brightness, 40);
    Present_State = 2'b11;
    #1;
    chk("alert_busy_comb",  Ramp_Busy, 0);
    chk("alert_attgt_comb", At_Target, 0);
    adv(1);                                   // k=3498, entry edge
    chk("alert_entry_bright", Brightness, 255);
    adv(7);                                   // k=3505
    chk("alert_hi_end", Brightness, 255);
    adv(1);                                   // k=3506
    chk("alert_lo_start", Brightness, 0);
    chk("alert_lo_busy",  Ramp_Busy,  0);
    chk("alert_lo_attgt", At_Target,  0);
    adv(7);                                   // k=3513
    chk("alert_lo_end", Brightness, 0);
    adv(1);                                   // k=3514
    chk("alert_hi2_start", Brightness, 255);
    adv(8);                                   // k=3522
    chk("alert_lo2_start", Brightness, 0);

    // Leave ALERT to ON: ramp from the held 0
    Present_State = 2'b10;
    adv(1);                                   // k=3523
    chk("exit_k3523_bright", Brightness, 0);
    chk("exit_k3523_busy",   Ramp_Busy,  1);
    adv(1);                                   // k=3524
    chk("exit_k3524_bright", Brightness, 1);
    adv(116);                                 // k=3640
    chk("exit_k3640_bright", Brightness, 30);
    adv(2);                                   // k=3642

    // Reset pulse mid-ramp at 30: clears without a clock edge
    Reset_n = 1'b0;
    #1;
    chk("arst_bright", Brightness, 0);
    chk("arst_pwm",    Lamp_PWM,   0);
    adv(1);
    chk("arst_held_bright", Brightness, 0);
    Reset_n = 1'b1;
    adv(3);                                   // k=3 after release
    chk("rel_k3_bright", Brightness, 0);
    chk("rel_k3_busy",   Ramp_Busy,  1);
    adv(1);                                   // k=4
    chk("rel_k4_bright", Brightness, 1);
    adv(4);                                   // k=8
    chk("rel_k8_bright", Brightness, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
